multiply_iter: RTL

MULTIPLY_ITER -- requirements
Module: multiply_iter

---
 rtl/multiply_iter.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/multiply_iter.sv
`default_nettype none
// ============================================================================
//  Module      : multiply_iter
//  Description : Iterative integer multiplier for MUL / MULH / MULHSU / MULHU.
//                Consumes BITS multiplier bits per cycle. Signed operands are
//                converted to magnitudes on acceptance, and the sign is
//                re-applied when the result is formed. The optional early-out
//                stops as soon as the remaining multiplier chunks are zero.
//                A branch mispredict flushes the uop when it is younger than
//                the branch.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, rst            clock, synchronous active-high reset
//    in_valid/in_ready   uop handshake
//    in_op               0=MUL 1=MULH 2=MULHSU 3=MULHU
//    in_srcA/in_srcB     operands (XLEN)
//    in_tag/in_sqN       destination tag / sequence number of the uop
//    br_taken/br_sqN     mispredicting branch and its sequence number
//    out_valid/out_ready result handshake
//    out_result          XLEN result; out_tag/out_sqN accompany out_valid
//    busy                high whenever the FSM is not idle
// ============================================================================
module multiply_iter #(
    parameter int XLEN      = 32,
    parameter int BITS      = 8,
    parameter int EARLY_OUT = 1,
    parameter int TAG_W     = 7,
    parameter int SQN_W     = 7
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [XLEN-1:0]  in_srcA,
    input  logic [XLEN-1:0]  in_srcB,
    input  logic [TAG_W-1:0] in_tag,
    input  logic [SQN_W-1:0] in_sqN,

    input  logic             br_taken,
    input  logic [SQN_W-1:0] br_sqN,

    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic [SQN_W-1:0] out_sqN,

    output logic             busy
);

    localparam int STAGES = XLEN / BITS;
    localparam int STG_W  = (STAGES > 1) ? $clog2(STAGES) : 1;
    // Shift amounts reach BITS*STAGES = XLEN, so size for the full 2*XLEN range.
    localparam int SH_W   = $clog2(2 * XLEN) + 1;
    localparam int PW     = XLEN + BITS;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] OP_MUL    = 2'd0;
    localparam logic [1:0] OP_MULH   = 2'd1;
    localparam logic [1:0] OP_MULHSU = 2'd2;
    localparam logic [1:0] OP_MULHU  = 2'd3;

    localparam logic [STG_W-1:0] C_LAST_STAGE = STG_W'(STAGES - 1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0]        state_q,  state_d;
    logic [STG_W-1:0]  stage_q,  stage_d;
    logic [XLEN-1:0]   a_q,      a_d;
    logic [XLEN-1:0]   b_q,      b_d;
    logic [2*XLEN-1:0] acc_q,    acc_d;
    logic              invert_q, invert_d;
    logic [1:0]        op_q,     op_d;
    logic [TAG_W-1:0]  tag_q,    tag_d;
    logic [SQN_W-1:0]  sqn_q,    sqn_d;
    logic [XLEN-1:0]   result_q, result_d;

    // ------------------------------------------------------------------------
    // Flush detection: an entry is killed only when strictly younger than the
    // branch, using wrap-around sequence-number distance.
    // ------------------------------------------------------------------------
    logic [SQN_W-1:0] w_held_diff;
    logic [SQN_W-1:0] w_in_diff;
    logic             w_held_flush;
    logic             w_in_flush;

    assign w_held_diff  = sqn_q - br_sqN;
    assign w_in_diff    = in_sqN - br_sqN;
    assign w_held_flush = br_taken && !w_held_diff[SQN_W-1] && (w_held_diff != '0);
    assign w_in_flush   = br_taken && !w_in_diff[SQN_W-1] && (w_in_diff != '0);

    // ------------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------------
    logic w_accept;

    assign in_ready = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
    assign w_accept = in_valid && in_ready && !w_in_flush;

    // ------------------------------------------------------------------------
    // Operand conditioning at acceptance. MUL is treated as signed*signed:
    // the low half of the product is identical either way, and magnitudes
    // let small negative multipliers take the early-out path.
    // ------------------------------------------------------------------------
    logic            w_sign_a;
    logic            w_sign_b;
    logic            w_neg_a;
    logic            w_neg_b;
    logic [XLEN-1:0] w_mag_a;
    logic [XLEN-1:0] w_mag_b;

    assign w_sign_a = (in_op != OP_MULHU);
    assign w_sign_b = (in_op == OP_MUL) || (in_op == OP_MULH);
    assign w_neg_a  = w_sign_a && in_srcA[XLEN-1];
    assign w_neg_b  = w_sign_b && in_srcB[XLEN-1];
    // -2^(XLEN-1) negates to itself, which is already the correct unsigned
    // magnitude, so the overflow case needs no special handling.
    assign w_mag_a  = w_neg_a ? (-in_srcA) : in_srcA;
    assign w_mag_b  = w_neg_b ? (-in_srcB) : in_srcB;

    // ------------------------------------------------------------------------
    // Per-cycle datapath: one BITS-wide multiplier chunk times |A|.
    // ------------------------------------------------------------------------
    logic [SH_W-1:0]   w_shamt;
    logic [SH_W-1:0]   w_shamt_next;
    logic [BITS-1:0]   w_chunk;
    logic [PW-1:0]     w_prod;
    logic [2*XLEN-1:0] w_part;
    logic [2*XLEN-1:0] w_sum;
    logic [2*XLEN-1:0] w_res;
    logic              w_rest_zero;
    logic              w_last;
    logic              w_finish;
    logic [XLEN-1:0]   w_res_sel;

    assign w_shamt      = SH_W'(stage_q) * SH_W'(BITS);
    assign w_shamt_next = w_shamt + SH_W'(BITS);
    assign w_chunk      = BITS'(b_q >> w_shamt);
    assign w_prod       = PW'(a_q) * PW'(w_chunk);
    assign w_part       = (2*XLEN)'(w_prod) << w_shamt;
    assign w_sum        = acc_q + w_part;
    assign w_res        = invert_q ? (-w_sum) : w_sum;
    assign w_res_sel    = (op_q == OP_MUL) ? w_res[XLEN-1:0] : w_res[2*XLEN-1:XLEN];

    // Remaining multiplier bits above the current chunk; shifting by XLEN on
    // the final stage yields zero, which is harmless.
    assign w_rest_zero  = ((b_q >> w_shamt_next) == '0);
    assign w_last       = (stage_q == C_LAST_STAGE);
    assign w_finish     = w_last || ((EARLY_OUT != 0) && w_rest_zero);

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        stage_d  = stage_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        invert_d = invert_q;
        op_d     = op_q;
        tag_d    = tag_q;
        sqn_d    = sqn_q;
        result_d = result_q;

        case (state_q)
            S_IDLE: begin
                state_d = S_IDLE;
            end
            S_CALC: begin
                if (w_held_flush) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d   = w_sum;
                    stage_d = stage_q + STG_W'(1);
                    if (w_finish) begin
                        state_d  = S_DONE;
                        result_d = w_res_sel;
                    end
                end
            end
            S_DONE: begin
                if (out_ready || w_held_flush) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Acceptance is only possible in IDLE or DONE. Once in_ready has been
        // advertised, an unflushed input is taken even if the held result is
        // being flushed on the same edge, so the handshake is never dropped.
        if (w_accept) begin
            state_d  = S_CALC;
            stage_d  = '0;
            acc_d    = '0;
            a_d      = w_mag_a;
            b_d      = w_mag_b;
            invert_d = w_neg_a ^ w_neg_b;
            op_d     = in_op;
            tag_d    = in_tag;
            sqn_d    = in_sqN;
        end
    end

    // ------------------------------------------------------------------------
    // Registers: only the control state is reset; the datapath is always
    // reloaded before use.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        stage_q  <= stage_d;
        a_q      <= a_d;
        b_q      <= b_d;
        acc_q    <= acc_d;
        invert_q <= invert_d;
        op_q     <= op_d;
        tag_q    <= tag_d;
        sqn_q    <= sqn_d;
        result_q <= result_d;
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign out_valid  = (state_q == S_DONE);
    assign busy       = (state_q != S_IDLE);
    assign out_result = result_q;
    assign out_tag    = tag_q;
    assign out_sqN    = sqn_q;

endmodule
`default_nettype wire
